// File: rtl/data_mem_dma.sv
// Block-transfer initiator for the data_mem port: word-by-word copy or constant fill.
// All outputs are registered and decoded from the next-state/pointer values.
module data_mem_dma #(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [15:0]          src_addr,
    input  logic [15:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [15:0]          fill_data,
    input  logic                 abort,
    output logic [15:0]          mem_access_addr,
    output logic [15:0]          mem_write_data,
    output logic                 mem_write_en,
    input  logic [15:0]          mem_read_data,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] words_done
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]    dst_ptr_q, dst_ptr_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0]    buf_q, buf_d;
    logic [DATA_W-1:0]    fill_q, fill_d;
    logic                 mode_q, mode_d;
    logic [LEN_WIDTH-1:0] words_done_q, words_done_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        buf_d        = buf_q;
        fill_d       = fill_q;
        mode_d       = mode_q;
        words_done_d = words_done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d    = src_addr;
                    dst_ptr_d    = dst_addr;
                    remaining_d  = length;
                    mode_d       = mode;
                    fill_d       = fill_data;
                    words_done_d = '0;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                buf_d     = mem_read_data;
                src_ptr_d = src_ptr_q + ADDR_W'(ADDR_STEP);
                state_d   = abort ? S_DONE : S_WR;
            end
            S_WR: begin
                dst_ptr_d    = dst_ptr_q + ADDR_W'(ADDR_STEP);
                words_done_d = words_done_q + LEN_WIDTH'(1);
                remaining_d  = remaining_q - LEN_WIDTH'(1);
                // The write presented this cycle always lands, even on abort
                if (abort || (remaining_q == LEN_WIDTH'(1))) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the port flops line up with it
    always_comb begin
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        if (state_d == S_RD) begin
            addr_d = src_ptr_d;
        end else if (state_d == S_WR) begin
            addr_d  = dst_ptr_d;
            wdata_d = mode_d ? fill_d : buf_d;
            we_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            buf_q        <= '0;
            fill_q       <= '0;
            mode_q       <= 1'b0;
            words_done_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            mode_q       <= mode_d;
            words_done_q <= words_done_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;
    assign mem_write_en    = we_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign words_done      = words_done_q;

endmodule
